ext_bus_arbiter: RTL and testbench

Two-port arbiter and sequencer for the shared 16-bit multiplexed external RAM bus: two address latches (lo/hi), a 16-bit data path, and split byte write enables. It accepts byte/half/word requests from two masters (port 0 = CPU, port 1 = DMA/boot loader), grants one at a time, and runs the latch/data sequence on the pads. Instantiated at chip top between the masters and the RAM pad ring.

---
 rtl/ext_bus_arbiter.sv | 217 +++++++++++++++++++++
 tb/tb_ext_bus_arbiter.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/ext_bus_arbiter.sv
// Two-port arbiter and sequencer for the shared 16-bit multiplexed external RAM bus.
// Pad outputs are decoded from the registered state and transaction fields only.
module ext_bus_arbiter #(
    parameter bit FIXED_PRIO = 1'b0,
    parameter int ADDR_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              we0,
    input  logic [1:0]        size0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [31:0]       wdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [1:0]        size1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [31:0]       wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic [31:0]       rdata,
    output logic              busy,
    output logic [15:0]       bus_out,
    input  logic [15:0]       bus_in,
    output logic              le_lo,
    output logic              le_hi,
    output logic              OEb,
    output logic              WEb_lo,
    output logic              WEb_hi,
    output logic              bus_dir
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ALO  = 3'd1,
        S_AHI  = 3'd2,
        S_D0   = 3'd3,
        S_ALO2 = 3'd4,
        S_D1   = 3'd5,
        S_DONE = 3'd6
    } state_t;

    state_t            state_r;
    state_t            state_s;
    logic              grant_valid_s;
    logic              grant_port_s;
    logic              port_r;
    logic              we_r;
    logic [1:0]        size_r;
    logic [ADDR_W-1:0] addr_r;
    logic [31:0]       wdata_r;
    logic              last_grant_r;
    logic              ack0_r;
    logic              ack1_r;
    logic [31:0]       rdata_r;
    logic              sel_we_s;
    logic [1:0]        sel_size_s;
    logic [ADDR_W-1:0] sel_addr_s;
    logic [31:0]       sel_wdata_s;
    logic [15:0]       ahi_s;
    logic              is_byte_s;
    logic              is_word_s;

    assign sel_we_s    = grant_port_s ? we1    : we0;
    assign sel_size_s  = grant_port_s ? size1  : size0;
    assign sel_addr_s  = grant_port_s ? addr1  : addr0;
    assign sel_wdata_s = grant_port_s ? wdata1 : wdata0;

    assign is_byte_s = (size_r == 2'd0);
    assign is_word_s = size_r[1];

    // Upper address bits for the high latch, zero-padded to the bus width.
    for (genvar gi = 0; gi < 16; gi++) begin : g_ahi
        if (17 + gi < ADDR_W) begin : g_bit
            assign ahi_s[gi] = addr_r[17+gi];
        end else begin : g_pad
            assign ahi_s[gi] = 1'b0;
        end
    end

    // Arbitration and next-state decode.
    always_comb begin
        state_s       = state_r;
        grant_valid_s = 1'b0;
        grant_port_s  = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (req0 && req1) begin
                    grant_valid_s = 1'b1;
                    grant_port_s  = FIXED_PRIO ? 1'b0 : ~last_grant_r;
                end else if (req0) begin
                    grant_valid_s = 1'b1;
                    grant_port_s  = 1'b0;
                end else if (req1) begin
                    grant_valid_s = 1'b1;
                    grant_port_s  = 1'b1;
                end else begin
                    grant_valid_s = 1'b0;
                end
                state_s = grant_valid_s ? S_ALO : S_IDLE;
            end
            S_ALO:   state_s = S_AHI;
            S_AHI:   state_s = S_D0;
            S_D0:    state_s = is_word_s ? S_ALO2 : S_DONE;
            S_ALO2:  state_s = S_D1;
            S_D1:    state_s = S_DONE;
            S_DONE:  state_s = S_IDLE;
            default: state_s = S_IDLE;
        endcase
    end

    // State, captured request, read data and ack registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= S_IDLE;
            port_r       <= 1'b0;
            we_r         <= 1'b0;
            size_r       <= 2'd0;
            addr_r       <= '0;
            wdata_r      <= 32'h0;
            last_grant_r <= 1'b1;
            ack0_r       <= 1'b0;
            ack1_r       <= 1'b0;
            rdata_r      <= 32'h0;
        end else begin
            state_r <= state_s;
            ack0_r  <= (state_s == S_DONE) && !port_r;
            ack1_r  <= (state_s == S_DONE) && port_r;
            if ((state_r == S_IDLE) && grant_valid_s) begin
                port_r  <= grant_port_s;
                we_r    <= sel_we_s;
                size_r  <= sel_size_s;
                addr_r  <= sel_addr_s;
                wdata_r <= sel_wdata_s;
                if (!sel_we_s) begin
                    rdata_r <= 32'h0;
                end
            end
            if ((state_r == S_D0) && !we_r) begin
                if (is_byte_s) begin
                    rdata_r[7:0] <= addr_r[0] ? bus_in[15:8] : bus_in[7:0];
                end else begin
                    rdata_r[15:0] <= bus_in;
                end
            end
            if ((state_r == S_D1) && !we_r) begin
                rdata_r[31:16] <= bus_in;
            end
            if (state_r == S_DONE) begin
                last_grant_r <= port_r;
            end
        end
    end

    // Pad sequencing decoded from the registered state; latch enables follow the high clock phase.
    always_comb begin
        bus_out = 16'h0000;
        le_lo   = 1'b0;
        le_hi   = 1'b0;
        OEb     = 1'b1;
        WEb_lo  = 1'b1;
        WEb_hi  = 1'b1;
        bus_dir = 1'b1;
        case (state_r)
            S_ALO: begin
                bus_out = addr_r[16:1];
                le_lo   = clk;
                bus_dir = 1'b0;
            end
            S_AHI: begin
                bus_out = ahi_s;
                le_hi   = clk;
                bus_dir = 1'b0;
            end
            S_D0: begin
                if (we_r) begin
                    bus_dir = 1'b0;
                    if (is_byte_s) begin
                        bus_out = addr_r[0] ? {wdata_r[7:0], 8'h00} : {8'h00, wdata_r[7:0]};
                        WEb_hi  = ~addr_r[0];
                        WEb_lo  = addr_r[0];
                    end else begin
                        bus_out = wdata_r[15:0];
                        WEb_hi  = 1'b0;
                        WEb_lo  = 1'b0;
                    end
                end else begin
                    OEb = 1'b0;
                end
            end
            S_ALO2: begin
                bus_out = addr_r[16:1] | 16'h0001;
                le_lo   = clk;
                bus_dir = 1'b0;
            end
            S_D1: begin
                if (we_r) begin
                    bus_dir = 1'b0;
                    bus_out = wdata_r[31:16];
                    WEb_hi  = 1'b0;
                    WEb_lo  = 1'b0;
                end else begin
                    OEb = 1'b0;
                end
            end
            default: begin
                bus_out = 16'h0000;
            end
        endcase
    end

    assign ack0  = ack0_r;
    assign ack1  = ack1_r;
    assign rdata = rdata_r;
    assign busy  = (state_r != S_IDLE);

endmodule

// File: tb/tb_ext_bus_arbiter.sv
// Directed bench for ext_bus_arbiter: a round-robin instance plus a fixed-priority
// instance sharing all inputs, checked with immediate assertions.
module tb_ext_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
    logic [1:0]  size0 = 2'd0, size1 = 2'd0;
    logic [31:0] addr0 = 32'h0, addr1 = 32'h0, wdata0 = 32'h0, wdata1 = 32'h0;
    logic [15:0] bus_in = 16'h0;

    logic        ack0, ack1, busy, le_lo, le_hi, OEb, WEb_lo, WEb_hi, bus_dir;
    logic [31:0] rdata;
    logic [15:0] bus_out;
    logic        fp_ack0, fp_ack1, fp_busy, fp_le_lo, fp_le_hi, fp_OEb, fp_WEb_lo, fp_WEb_hi, fp_bus_dir;
    logic [31:0] fp_rdata;
    logic [15:0] fp_bus_out;

    int total = 0;
    int bad   = 0;
    int viol  = 0;

    ext_bus_arbiter #(.FIXED_PRIO(1'b0), .ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .we0(we0), .size0(size0), .addr0(addr0), .wdata0(wdata0),
        .req1(req1), .we1(we1), .size1(size1), .addr1(addr1), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .rdata(rdata), .busy(busy),
        .bus_out(bus_out), .bus_in(bus_in), .le_lo(le_lo), .le_hi(le_hi),
        .OEb(OEb), .WEb_lo(WEb_lo), .WEb_hi(WEb_hi), .bus_dir(bus_dir)
    );

    ext_bus_arbiter #(.FIXED_PRIO(1'b1), .ADDR_W(32)) dut_fp (
        .clk(clk), .rst(rst),
        .req0(req0), .we0(we0), .size0(size0), .addr0(addr0), .wdata0(wdata0),
        .req1(req1), .we1(we1), .size1(size1), .addr1(addr1), .wdata1(wdata1),
        .ack0(fp_ack0), .ack1(fp_ack1), .rdata(fp_rdata), .busy(fp_busy),
        .bus_out(fp_bus_out), .bus_in(bus_in), .le_lo(fp_le_lo), .le_hi(fp_le_hi),
        .OEb(fp_OEb), .WEb_lo(fp_WEb_lo), .WEb_hi(fp_WEb_hi), .bus_dir(fp_bus_dir)
    );

    always #5 clk = ~clk;

    // Pad-level invariants watched continuously while clk is low.
    always @(negedge clk) begin
        if (!OEb && !bus_dir) viol = viol + 1;
        if (le_lo || le_hi) viol = viol + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) else begin
            bad = bad + 1;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        step();
        step();
        chk("rst_ack0", ack0, 1'b0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_bus_out", bus_out, 16'h0);
        chk("rst_oeb", OEb, 1'b1);
        chk("rst_web", {WEb_hi, WEb_lo}, 2'b11);
        chk("rst_dir", bus_dir, 1'b1);
        chk("rst_busy", busy, 1'b0);
        rst = 1'b0;

        // Port 0 word read at 0x1234
        req0 = 1'b1; we0 = 1'b0; size0 = 2'd2; addr0 = 32'h0000_1234;
        step();
        chk("wr_alo_bus", bus_out, 16'h091A);
        chk("wr_alo_le", le_lo, 1'b1);
        chk("wr_alo_dir", bus_dir, 1'b0);
        chk("wr_busy", busy, 1'b1);
        #5;
        chk("wr_alo_le_low", le_lo, 1'b0);
        step();
        chk("wr_ahi_bus", bus_out, 16'h0000);
        chk("wr_ahi_le", le_hi, 1'b1);
        bus_in = 16'hBEEF;
        step();
        chk("wr_d0_oeb", OEb, 1'b0);
        chk("wr_d0_dir", bus_dir, 1'b1);
        step();
        chk("wr_alo2_bus", bus_out, 16'h091B);
        chk("wr_no_ack_yet", ack0, 1'b0);
        bus_in = 16'hCAFE;
        step();
        chk("wr_d1_oeb", OEb, 1'b0);
        step();
        chk("wr_ack0", ack0, 1'b1);
        chk("wr_ack1", ack1, 1'b0);
        chk("wr_rdata", rdata, 32'hCAFEBEEF);
        req0 = 1'b0;
        step();
        chk("wr_ack_pulse", ack0, 1'b0);
        chk("wr_idle", busy, 1'b0);
        chk("wr_rdata_hold", rdata, 32'hCAFEBEEF);

        // Port 1 byte write 0xA5 to 0x0002_0003
        req1 = 1'b1; we1 = 1'b1; size1 = 2'd0; addr1 = 32'h0002_0003; wdata1 = 32'h0000_00A5;
        step();
        chk("bw_alo_bus", bus_out, 16'h0001);
        step();
        chk("bw_ahi_bus", bus_out, 16'h0001);
        step();
        chk("bw_d0_bus", bus_out, 16'hA500);
        chk("bw_d0_web", {WEb_hi, WEb_lo}, 2'b01);
        chk("bw_d0_dir", bus_dir, 1'b0);
        chk("bw_d0_oeb", OEb, 1'b1);
        step();
        chk("bw_ack1", ack1, 1'b1);
        chk("bw_ack0", ack0, 1'b0);
        chk("bw_busy_done", busy, 1'b1);
        req1 = 1'b0;
        step();
        chk("bw_busy_fall", busy, 1'b0);
        chk("bw_rdata_keep", rdata, 32'hCAFEBEEF);

        // Port 0 half read at 0x11
        req0 = 1'b1; we0 = 1'b0; size0 = 2'd1; addr0 = 32'h0000_0011;
        step();
        chk("hr_alo_bus", bus_out, 16'h0008);
        step();
        step();
        bus_in = 16'h8001;
        step();
        chk("hr_ack0_no_d1", ack0, 1'b1);
        chk("hr_rdata", rdata, 32'h0000_8001);
        req0 = 1'b0;
        step();

        // Port 0 byte read at odd address 0x5
        req0 = 1'b1; we0 = 1'b0; size0 = 2'd0; addr0 = 32'h0000_0005;
        step();
        step();
        step();
        bus_in = 16'h12AB;
        step();
        chk("br_ack0", ack0, 1'b1);
        chk("br_rdata", rdata, 32'h0000_0012);
        req0 = 1'b0;
        step();

        // Reset during AHI of a word write, then a clean retry
        req0 = 1'b1; we0 = 1'b1; size0 = 2'd2; addr0 = 32'h0003_0000; wdata0 = 32'h1122_3344;
        step();
        step();
        chk("rs_ahi_le", le_hi, 1'b1);
        rst = 1'b1;
        #1;
        chk("rs_bus_out", bus_out, 16'h0000);
        chk("rs_le_hi", le_hi, 1'b0);
        chk("rs_dir", bus_dir, 1'b1);
        chk("rs_busy", busy, 1'b0);
        req0 = 1'b0;
        rst = 1'b0;
        step();
        chk("rs_no_ack", ack0, 1'b0);
        chk("rs_still_idle", busy, 1'b0);
        req0 = 1'b1;
        step();
        chk("ww_alo_bus", bus_out, 16'h8000);
        chk("ww_alo_le", le_lo, 1'b1);
        step();
        chk("ww_ahi_bus", bus_out, 16'h0001);
        step();
        chk("ww_d0_bus", bus_out, 16'h3344);
        chk("ww_d0_web", {WEb_hi, WEb_lo}, 2'b00);
        step();
        chk("ww_alo2_bus", bus_out, 16'h8001);
        step();
        chk("ww_d1_bus", bus_out, 16'h1122);
        chk("ww_d1_web", {WEb_hi, WEb_lo}, 2'b00);
        step();
        chk("ww_ack0", ack0, 1'b1);
        req0 = 1'b0;
        step();

        // Simultaneous held requests: last grant was port 0, so round-robin starts with port 1
        req0 = 1'b1; we0 = 1'b0; size0 = 2'd0; addr0 = 32'h0000_0000;
        req1 = 1'b1; we1 = 1'b0; size1 = 2'd0; addr1 = 32'h0000_0002;
        for (int k = 0; k < 4; k++) begin
            int waited;
            waited = 0;
            while (!(ack0 || ack1) && waited < 12) begin
                step();
                waited = waited + 1;
            end
            chk("rr_timeout", (waited < 12) ? 1'b1 : 1'b0, 1'b1);
            chk("rr_grant_port1", ack1, (k % 2 == 0) ? 1'b1 : 1'b0);
            chk("rr_grant_port0", ack0, (k % 2 == 0) ? 1'b0 : 1'b1);
            chk("fp_ack0", fp_ack0, 1'b1);
            chk("fp_ack1_starved", fp_ack1, 1'b0);
            step();
        end
        req0 = 1'b0;
        req1 = 1'b0;
        step();
        step();
        chk("pad_invariants", viol, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
